// File: rtl/sdram_port_scheduler_pkg.sv
// Shared types and helpers for the SDRAM port scheduler: FSM states, grant owner,
// byte-strobe encodings and the byte-lane select used on reads.
package sdram_port_scheduler_pkg;

  typedef enum logic [2:0] {StSync, StIdle, StIssue, StWait, StDone} sched_state_t;
  typedef enum logic {GCpu, GFdc} grant_t;

  localparam logic [1:0] DsLo   = 2'b01;
  localparam logic [1:0] DsHi   = 2'b10;
  localparam logic [1:0] DsBoth = 2'b11;

  function automatic logic [1:0] byte_strobe(input logic we, input logic a0);
    if (!we) return DsBoth;
    return a0 ? DsHi : DsLo;
  endfunction

  function automatic logic [7:0] read_byte(input logic [15:0] q, input logic a0);
    return a0 ? q[15:8] : q[7:0];
  endfunction

endpackage

// File: rtl/sdram_port_scheduler_if.sv
// Bundles the CPU bus, FDC buffer port and SDRAM toggle-handshake port seen by the scheduler.
// master is the scheduler's view; slave is the surrounding system (CPU, FDC, SDRAM controller).
interface sdram_port_scheduler_if #(
  parameter int unsigned MemAw = 24,
  parameter int unsigned FdcAw = 16
);
  logic             cpu_cs;
  logic             cpu_oe;
  logic             cpu_we;
  logic [15:0]      cpu_a;
  logic [7:0]       cpu_d;
  logic [7:0]       cpu_q;
  logic             fdc_req;
  logic             fdc_we;
  logic [FdcAw-1:0] fdc_a;
  logic [7:0]       fdc_d;
  logic [7:0]       fdc_q;
  logic             fdc_ack;
  logic             mem_req;
  logic             mem_ack;
  logic [MemAw-1:0] mem_a;
  logic             mem_we;
  logic [1:0]       mem_ds;
  logic [15:0]      mem_d;
  logic [15:0]      mem_q;
  logic             busy;
  logic             timeout_err;

  modport master (
    input  cpu_cs, cpu_oe, cpu_we, cpu_a, cpu_d,
    input  fdc_req, fdc_we, fdc_a, fdc_d,
    input  mem_ack, mem_q,
    output cpu_q, fdc_q, fdc_ack,
    output mem_req, mem_a, mem_we, mem_ds, mem_d,
    output busy, timeout_err
  );

  modport slave (
    output cpu_cs, cpu_oe, cpu_we, cpu_a, cpu_d,
    output fdc_req, fdc_we, fdc_a, fdc_d,
    output mem_ack, mem_q,
    input  cpu_q, fdc_q, fdc_ack,
    input  mem_req, mem_a, mem_we, mem_ds, mem_d,
    input  busy, timeout_err
  );
endinterface

// File: rtl/sdram_port_scheduler_cpu_access_detect.sv
// Turns the 6502 level strobes into access triggers and holds the latest one in a
// single pending slot until the scheduler takes it.
module sdram_port_scheduler_cpu_access_detect (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_cs,
  input  logic        cpu_oe,
  input  logic        cpu_we,
  input  logic [15:0] cpu_a,
  input  logic [7:0]  cpu_d,
  input  logic        take,
  output logic        pend_valid,
  output logic [15:0] pend_a,
  output logic [7:0]  pend_d,
  output logic        pend_we
);

  logic        rd, wr, trigger;
  logic        rd_q, wr_q;
  logic [15:0] a_q;

  assign rd = cpu_cs & cpu_oe;
  assign wr = cpu_cs & cpu_we;
  // A held read strobe with a new address is a fresh read (back-to-back CPU cycles).
  assign trigger = (rd & ~rd_q) | (wr & ~wr_q) | (rd & (cpu_a != a_q));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      a_q        <= '0;
      pend_valid <= 1'b0;
      pend_a     <= '0;
      pend_d     <= '0;
      pend_we    <= 1'b0;
    end else begin
      rd_q <= rd;
      wr_q <= wr;
      a_q  <= cpu_a;
      // A trigger coinciding with a take re-arms the slot so the newer access is not lost.
      if (trigger) begin
        pend_valid <= 1'b1;
        pend_a     <= cpu_a;
        pend_d     <= cpu_d;
        pend_we    <= wr;
      end else if (take) begin
        pend_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sdram_port_scheduler.sv
// Arbitrates one toggle-handshake SDRAM port between the CPU RAM bus and the FDC buffer,
// CPU first with a bounded FDC starvation guard and an ack timeout.
module sdram_port_scheduler
  import sdram_port_scheduler_pkg::*;
#(
  parameter int unsigned      MemAw     = 24,
  parameter int unsigned      FdcAw     = 16,
  parameter logic [MemAw-1:0] FdcBase   = MemAw'(24'h010000),
  parameter int unsigned      StarveMax = 4,
  parameter int unsigned      Timeout   = 255
) (
  input logic                    clk,
  input logic                    reset,
  sdram_port_scheduler_if.master bus
);

  localparam int unsigned StarveW = $clog2(StarveMax + 1);
  localparam int unsigned TmoW    = $clog2(Timeout + 1);

  sched_state_t     state_q;
  grant_t           grant_q;
  logic             mem_req_q, mem_we_q, busy_q, fdc_ack_q, timeout_err_q;
  logic [MemAw-1:0] mem_a_q;
  logic [1:0]       mem_ds_q;
  logic [15:0]      mem_d_q;
  logic [7:0]       cpu_q_q, fdc_q_q;
  logic [StarveW-1:0] starve_q;
  logic [TmoW-1:0]    tmo_q;

  logic             pend_valid, pend_we;
  logic [15:0]      pend_a;
  logic [7:0]       pend_d;
  logic [FdcAw-1:0] fdc_a;
  logic             fdc_turn, grant_cpu, grant_fdc;
  logic [MemAw-1:0] cpu_mem_a, fdc_mem_a;

  assign fdc_a     = bus.fdc_a;
  assign fdc_turn  = bus.fdc_req && (starve_q == StarveW'(StarveMax));
  assign grant_cpu = (state_q == StIdle) && pend_valid && !fdc_turn;
  assign grant_fdc = (state_q == StIdle) && bus.fdc_req && (!pend_valid || fdc_turn);
  assign cpu_mem_a = MemAw'(pend_a);
  assign fdc_mem_a = FdcBase + MemAw'(fdc_a);

  sdram_port_scheduler_cpu_access_detect u_detect (
    .clk        (clk),
    .reset      (reset),
    .cpu_cs     (bus.cpu_cs),
    .cpu_oe     (bus.cpu_oe),
    .cpu_we     (bus.cpu_we),
    .cpu_a      (bus.cpu_a),
    .cpu_d      (bus.cpu_d),
    .take       (grant_cpu),
    .pend_valid (pend_valid),
    .pend_a     (pend_a),
    .pend_d     (pend_d),
    .pend_we    (pend_we)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StSync;
      grant_q       <= GCpu;
      mem_req_q     <= 1'b0;
      mem_a_q       <= '0;
      mem_we_q      <= 1'b0;
      mem_ds_q      <= '0;
      mem_d_q       <= '0;
      busy_q        <= 1'b0;
      cpu_q_q       <= '0;
      fdc_q_q       <= '0;
      fdc_ack_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      starve_q      <= '0;
      tmo_q         <= '0;
    end else begin
      fdc_ack_q <= 1'b0;
      if (!bus.fdc_req) starve_q <= '0;
      case (state_q)
        StSync: begin
          mem_req_q <= bus.mem_ack;
          state_q   <= StIdle;
        end
        // Request outputs are loaded and mem_req toggled on the grant edge itself.
        StIdle: begin
          if (grant_cpu) begin
            grant_q   <= GCpu;
            mem_a_q   <= cpu_mem_a;
            mem_we_q  <= pend_we;
            mem_ds_q  <= byte_strobe(pend_we, pend_a[0]);
            mem_d_q   <= {pend_d, pend_d};
            mem_req_q <= ~mem_req_q;
            busy_q    <= 1'b1;
            state_q   <= StIssue;
            if (bus.fdc_req && (starve_q != StarveW'(StarveMax))) begin
              starve_q <= starve_q + StarveW'(1);
            end
          end else if (grant_fdc) begin
            grant_q   <= GFdc;
            mem_a_q   <= fdc_mem_a;
            mem_we_q  <= bus.fdc_we;
            mem_ds_q  <= byte_strobe(bus.fdc_we, fdc_a[0]);
            mem_d_q   <= {bus.fdc_d, bus.fdc_d};
            mem_req_q <= ~mem_req_q;
            busy_q    <= 1'b1;
            starve_q  <= '0;
            state_q   <= StIssue;
          end
        end
        StIssue: begin
          tmo_q   <= '0;
          state_q <= StWait;
        end
        StWait: begin
          if (bus.mem_ack == mem_req_q) begin
            state_q <= StDone;
            if (grant_q == GCpu) begin
              if (!mem_we_q) cpu_q_q <= read_byte(bus.mem_q, mem_a_q[0]);
            end else begin
              fdc_ack_q <= 1'b1;
              if (!mem_we_q) fdc_q_q <= read_byte(bus.mem_q, mem_a_q[0]);
            end
          end else if (tmo_q == TmoW'(Timeout - 1)) begin
            // Abandon: realign the toggle pair; a still-requesting FDC is simply retried.
            timeout_err_q <= 1'b1;
            mem_req_q     <= bus.mem_ack;
            busy_q        <= 1'b0;
            state_q       <= StIdle;
          end else begin
            tmo_q <= tmo_q + TmoW'(1);
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StSync;
      endcase
    end
  end

  assign bus.mem_req     = mem_req_q;
  assign bus.mem_a       = mem_a_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_ds      = mem_ds_q;
  assign bus.mem_d       = mem_d_q;
  assign bus.busy        = busy_q;
  assign bus.cpu_q       = cpu_q_q;
  assign bus.fdc_q       = fdc_q_q;
  assign bus.fdc_ack     = fdc_ack_q;
  assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_sdram_port_scheduler.sv
// Directed bench for sdram_port_scheduler: a small SDRAM responder with programmable ack delay
// plus a linear sequence of CPU/FDC accesses with hand-computed expectations.
module tb_sdram_port_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  logic ack_en = 1'b0;
  logic ack_init = 1'b1;
  int   ack_delay = 5;
  int   dly = 0;
  logic busy_prev = 1'b0;
  logic [23:0] log_q[$];
  int   ack_cnt = 0;

  int   n, base, ack_snap, cpu_run;
  logic [23:0] entry;

  sdram_port_scheduler_if #(.MemAw(24), .FdcAw(16)) bus ();

  sdram_port_scheduler dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // SDRAM responder: answers a pending toggle after ack_delay+1 cycles; logs each issued address.
  always @(negedge clk) begin
    if (rst) begin
      bus.mem_ack = ack_init;
      dly = 0;
    end else if (ack_en && (bus.mem_req !== bus.mem_ack)) begin
      if (dly >= ack_delay) begin
        bus.mem_ack = bus.mem_req;
        dly = 0;
      end else begin
        dly++;
      end
    end else begin
      dly = 0;
    end
    if (bus.busy === 1'b1 && busy_prev !== 1'b1) log_q.push_back(bus.mem_a);
    if (bus.fdc_ack === 1'b1) ack_cnt++;
    busy_prev = bus.busy;
  end

  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (bus.busy === 1'b1 && k < 600) begin
      tick(1);
      k++;
    end
    check(tag, 32'(bus.busy), 0);
  endtask

  task automatic wait_fdc_ack(input string tag);
    int k = 0;
    while (bus.fdc_ack !== 1'b1 && k < 600) begin
      tick(1);
      k++;
    end
    check(tag, 32'(bus.fdc_ack), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cpu_cs = 0; bus.cpu_oe = 0; bus.cpu_we = 0; bus.cpu_a = 0; bus.cpu_d = 0;
    bus.fdc_req = 0; bus.fdc_we = 0; bus.fdc_a = 0; bus.fdc_d = 0;
    bus.mem_q = 0;

    // Reset, then SYNC copies mem_ack=1 into mem_req with no access started.
    tick(2);
    check("rst_mem_req", 32'(bus.mem_req), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_cpu_q", 32'(bus.cpu_q), 0);
    check("rst_timeout_err", 32'(bus.timeout_err), 0);
    check("rst_fdc_ack", 32'(bus.fdc_ack), 0);
    rst = 0;
    tick(1);
    check("sync_mem_req", 32'(bus.mem_req), 1);
    tick(3);
    check("sync_no_access", 32'(bus.busy), 0);
    check("sync_req_hold", 32'(bus.mem_req), 1);
    ack_en = 1;

    // CPU read of odd byte: toggle two cycles after the strobe, high byte returned.
    bus.mem_q = 16'hA55A; bus.cpu_a = 16'h0401; bus.cpu_cs = 1; bus.cpu_oe = 1;
    tick(1);
    check("rd_latency", 32'(bus.mem_req), 1);
    tick(1);
    check("rd_toggle", 32'(bus.mem_req), 0);
    check("rd_mem_a", 32'(bus.mem_a), 'h000401);
    check("rd_mem_ds", 32'(bus.mem_ds), 'h3);
    check("rd_mem_we", 32'(bus.mem_we), 0);
    check("rd_busy", 32'(bus.busy), 1);
    wait_idle("rd_done");
    check("rd_cpu_q", 32'(bus.cpu_q), 'hA5);
    bus.cpu_cs = 0; bus.cpu_oe = 0;
    tick(2);

    // CPU write even then odd address.
    bus.cpu_d = 8'h3C; bus.cpu_a = 16'h0400; bus.cpu_cs = 1; bus.cpu_we = 1;
    tick(2);
    check("wr_mem_a", 32'(bus.mem_a), 'h000400);
    check("wr_mem_ds", 32'(bus.mem_ds), 'h1);
    check("wr_mem_d", 32'(bus.mem_d), 'h3C3C);
    check("wr_mem_we", 32'(bus.mem_we), 1);
    wait_idle("wr_done");
    check("wr_cpu_q_held", 32'(bus.cpu_q), 'hA5);
    bus.cpu_cs = 0; bus.cpu_we = 0;
    tick(2);
    bus.cpu_d = 8'h5A; bus.cpu_a = 16'h0401; bus.cpu_cs = 1; bus.cpu_we = 1;
    tick(2);
    check("wr_odd_ds", 32'(bus.mem_ds), 'h2);
    check("wr_odd_d", 32'(bus.mem_d), 'h5A5A);
    wait_idle("wr_odd_done");
    bus.cpu_cs = 0; bus.cpu_we = 0;
    tick(2);

    // FDC read: offset into the FDC region, single-cycle ack, low byte returned.
    bus.mem_q = 16'hBEEF; bus.fdc_a = 16'h0010; bus.fdc_we = 0; bus.fdc_req = 1;
    tick(1);
    check("fdc_rd_mem_a", 32'(bus.mem_a), 'h010010);
    check("fdc_rd_mem_ds", 32'(bus.mem_ds), 'h3);
    check("fdc_rd_busy", 32'(bus.busy), 1);
    wait_fdc_ack("fdc_rd_ack");
    bus.fdc_req = 0;
    check("fdc_rd_q", 32'(bus.fdc_q), 'hEF);
    tick(1);
    check("fdc_ack_pulse", 32'(bus.fdc_ack), 0);
    wait_idle("fdc_rd_done");
    tick(3);
    check("fdc_no_reissue", 32'(bus.busy), 0);

    // FDC write at the top of its window, odd byte.
    bus.fdc_a = 16'hFFFF; bus.fdc_d = 8'h77; bus.fdc_we = 1; bus.fdc_req = 1;
    tick(1);
    check("fdc_wr_mem_a", 32'(bus.mem_a), 'h01FFFF);
    check("fdc_wr_mem_ds", 32'(bus.mem_ds), 'h2);
    check("fdc_wr_mem_d", 32'(bus.mem_d), 'h7777);
    check("fdc_wr_mem_we", 32'(bus.mem_we), 1);
    wait_fdc_ack("fdc_wr_ack");
    bus.fdc_req = 0; bus.fdc_we = 0;
    wait_idle("fdc_wr_done");
    tick(2);

    // Starvation guard: CPU re-triggers every cycle, FDC gets in after exactly 4 CPU grants.
    base = log_q.size();
    bus.cpu_a = 16'h0100; bus.cpu_cs = 1; bus.cpu_oe = 1;
    tick(1);
    bus.fdc_a = 16'h0020; bus.fdc_req = 1;
    n = 0;
    while (bus.fdc_ack !== 1'b1 && n < 600) begin
      bus.cpu_a = bus.cpu_a + 16'd1;
      tick(1);
      n++;
    end
    check("starve_ack", 32'(bus.fdc_ack), 1);
    bus.fdc_req = 0; bus.cpu_cs = 0; bus.cpu_oe = 0;
    wait_idle("starve_idle1");
    tick(2);
    wait_idle("starve_idle2");
    tick(2);
    cpu_run = 0;
    while ((base + cpu_run) < log_q.size() && log_q[base + cpu_run] < 24'h010000) cpu_run++;
    check("starve_cpu_grants", 32'(cpu_run), 4);
    entry = (log_q.size() > base + 4) ? log_q[base + 4] : 24'hFFFFFF;
    check("starve_fdc_a", 32'(entry), 'h010020);

    // Ack never comes: 1 grant + 1 issue + 255 wait cycles, then error and FDC retry.
    ack_en = 0;
    ack_snap = ack_cnt;
    bus.mem_q = 16'h1234; bus.fdc_a = 16'h0030; bus.fdc_we = 0; bus.fdc_req = 1;
    n = 0;
    while (bus.timeout_err !== 1'b1 && n < 600) begin
      tick(1);
      n++;
    end
    check("tmo_cycles", 32'(n), 257);
    check("tmo_err", 32'(bus.timeout_err), 1);
    check("tmo_busy", 32'(bus.busy), 0);
    check("tmo_realign", 32'(bus.mem_req), 32'(bus.mem_ack));
    check("tmo_no_ack", 32'(ack_cnt), 32'(ack_snap));
    tick(1);
    check("tmo_retry_busy", 32'(bus.busy), 1);
    check("tmo_retry_a", 32'(bus.mem_a), 'h010030);
    ack_en = 1;
    wait_fdc_ack("tmo_retry_ack");
    bus.fdc_req = 0;
    check("tmo_retry_q", 32'(bus.fdc_q), 'h34);
    wait_idle("tmo_retry_done");
    check("tmo_sticky", 32'(bus.timeout_err), 1);
    tick(2);

    // Address change mid-access re-arms the CPU; FDC request withdrawn before grant.
    base = log_q.size();
    ack_snap = ack_cnt;
    bus.mem_q = 16'h6699; bus.cpu_a = 16'h0500; bus.cpu_cs = 1; bus.cpu_oe = 1;
    tick(2);
    check("rearm_busy", 32'(bus.busy), 1);
    bus.cpu_a = 16'h0502; bus.fdc_a = 16'h0040; bus.fdc_req = 1;
    tick(2);
    bus.fdc_req = 0;
    wait_idle("rearm_idle1");
    tick(2);
    wait_idle("rearm_idle2");
    tick(2);
    bus.cpu_cs = 0; bus.cpu_oe = 0;
    check("rearm_count", 32'(log_q.size() - base), 2);
    entry = (log_q.size() > base + 1) ? log_q[base + 1] : 24'hFFFFFF;
    check("rearm_a", 32'(entry), 'h000502);
    check("rearm_cpu_q", 32'(bus.cpu_q), 'h99);
    check("withdraw_no_ack", 32'(ack_cnt), 32'(ack_snap));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
